vv_alu_pipelined: RTL and testbench
===================================

# vv_alu_pipelined

Parametrised second-generation vector-vector ALU for the trace-processing pipeline. Each incoming N-lane vector is combined lane-wise with a vector read from a local vector register file (VVRF); the operation is selected by per-chain firmware. The result can optionally be written back ("cached") into the VVRF. Compared with the first-generation ALU, this block adds:
- signed min/max operations and optional saturation;
- an asynchronous reset;
- runtime firmware programming over the config bus;
- same-edge write-to-read forwarding in the VVRF.

## Interface
Parameters:
- N, 8, lanes per vector
- DATA_WIDTH, 32, bits per lane, signed two's complement
- MAX_CHAINS, 4, firmware entries, one per chain; must be a power of 2 and at least 2
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block
- VVRF_SIZE, 8, VVRF depth in vectors; must be a power of 2 and at most 256
- SATURATE, 0, 1 selects saturating add/sub/mul, 0 selects wrap-around

Ports:
- clk  in  1  clock; one clock domain; all logic is posedge
- rst_n  in  1  asynchronous, active-low reset
- tracing  in  1  global enable; when low, incoming vectors are dropped
- valid_in  in  1  input vector valid
- eof_in  in  1  end-of-frame tag carried with the vector
- chainId_in  in  clog2(MAX_CHAINS)  selects the firmware entry for this vector
- configId  in  8  config bus target id
- configData  in  8  config bus byte
- vector_in  in  N x DATA_WIDTH  input lanes
- vector_out  out  N x DATA_WIDTH  result lanes
- chainId_out  out  clog2(MAX_CHAINS)  chainId aligned with vector_out
- valid_out  out  1  result valid
- eof_out  out  1  eof aligned with vector_out

## Operation
Firmware per chain c:
- op[c] (8b)
- addr_rd[c]: VVRF read address; only the low clog2(VVRF_SIZE) bits are used
- cache_en[c]: bit 0 of its byte
- cache_addr[c]: VVRF write address; low clog2(VVRF_SIZE) bits
- Reset value of every field is 0, which gives pass-through with no caching.

Config programming:
- A byte is written on every clock edge where configId == PERSONAL_CONFIG_ID.
- A byte pointer k runs over 0..4*MAX_CHAINS-1 and wraps to 0 after the last value. k resets to 0.
- Byte k goes to chain k/4. Field k%4 selects: 0 = op, 1 = addr_rd, 2 = cache_en, 3 = cache_addr.

Firmware snapshot:
- Firmware is looked up when a vector is accepted and travels down the pipeline with it.
- A config write therefore never affects a vector already in flight.
- A vector accepted on the same edge as a config write sees the old value.

ALU ops, lane-wise, where a = vector_in lane and b = VVRF lane:
- 0: a
- 1: a+b
- 2: a-b
- 3: a*b. The full 2*DATA_WIDTH product is formed; the low DATA_WIDTH bits are kept.
- 4: signed max(a,b)
- 5: signed min(a,b)
- 6: b
- 7–255: a (same as op 0)

Saturation:
- SATURATE=1 applies to ops 1–3 only.
- The result is clamped to [-2^(DW-1), 2^(DW-1)-1].

Caching:
- The VVRF is written only when an accepted vector reaches the output stage with cache_en=1.
- It writes the full result vector to VVRF[cache_addr].

VVRF behaviour:
- One synchronous read port and one write port.
- Contents are NOT cleared by reset, so it can map to RAM. The bench must write an entry before reading it.

Acceptance:
- A vector is accepted when valid_in && tracing.
- When tracing is low, no vector is accepted, and any in-flight vector is still delivered and cached.

## Timing
- Latency is exactly 2 cycles. A vector accepted at edge t appears with valid_out=1 after edge t+1, and is written to the VVRF at edge t+1.
- Stage 1 (edge t): vector, eof, chainId and firmware snapshot are registered; the VVRF is read at addr_rd.
- Stage 2 (edge t+1): the ALU result is registered into vector_out/eof_out/chainId_out, and the VVRF is written if caching.
- Full throughput: one vector per cycle. There is no backpressure and no stall.
- Forwarding: if a VVRF write and a stage-1 read hit the same address on the same edge, the read returns the data being written.
- valid_out is high for exactly one cycle per accepted vector. eof_out and chainId_out are meaningful only while valid_out=1.
- Reset, asserted at any time:
  - valid_out, eof_out and chainId_out go to 0, and vector_out lanes go to 0.
  - Internal valids clear, so in-flight vectors are discarded and no VVRF write occurs.
  - Firmware and the config pointer return to 0.
- Deassert rst_n synchronously to clk; the bench must do so.

## Test plan
- Reset and pass-through: reset, then with tracing=1 send vector_in lanes 1..8 on chain 0 → 2 cycles later valid_out=1, vector_out=1..8, chainId_out=0.
- Config and cache: program chain1 as op=0, cache_en=1, cache_addr=3. Send {5,5,...} on chain1. Then program chain2 as op=1, addr_rd=3, send {2,...} on chain2 → output {7,...}.
- Forwarding: chain1 caches to addr 3 as above, and a chain2 read of addr 3 follows on the very next cycle. Precondition: VVRF[3] is first loaded to a value other than {9,...}. Send {9,...} on chain1, then {1,...} on chain2 on the next cycle → output {10,...}, not the stale value.
- Saturation: SATURATE=1, DW=8, op=1 with a=100 and b=100 → 127. op=2 with a=-100 and b=100 → -128. op=3 with a=16 and b=16 → 127. With SATURATE=0, the same op=1 case gives -56.
- Min/max and ops: op=4 with a=-3 and b=2 → 2. op=5 → -3. op=6 → 2. op=200 → -3.
- Tracing and reset mid-flight: drop tracing while valid_in=1 → no valid_out for that input, but an earlier in-flight vector still emerges. Pulse rst_n low with a vector in stage 1 → valid_out stays 0, no cache write, and firmware reads back as pass-through.

Source files
------------

// File: rtl/vv_alu_pipelined.sv
// vv_alu_pipelined: two-stage lane-wise ALU combining each input vector with
// a vector from a local register file (VVRF). Per-chain firmware selects the
// op, the VVRF read address and whether the result is cached back into the VVRF.
module vv_alu_pipelined #(
  parameter  int N                  = 8,
  parameter  int DATA_WIDTH         = 32,
  parameter  int MAX_CHAINS         = 4,
  parameter  int PERSONAL_CONFIG_ID = 0,
  parameter  int VVRF_SIZE          = 8,
  parameter  int SATURATE           = 0,
  localparam int CW                 = $clog2(MAX_CHAINS),
  localparam int AW                 = (VVRF_SIZE > 1) ? $clog2(VVRF_SIZE) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tracing,
  input  logic                           valid_in,
  input  logic                           eof_in,
  input  logic [CW-1:0]                  chainId_in,
  input  logic [7:0]                     configId,
  input  logic [7:0]                     configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
  output logic [CW-1:0]                  chainId_out,
  output logic                           valid_out,
  output logic                           eof_out
);

  localparam int   DW     = DATA_WIDTH;
  localparam int   PW     = CW + 2;
  localparam logic SAT_EN = (SATURATE != 0);

  // Keep the low DW bits of a 2*DW-bit signed value, optionally clamping
  // to the representable signed range when the value does not fit.
  function automatic logic signed [DW-1:0] sat_trunc(input logic signed [2*DW-1:0] x,
                                                      input logic sat_en);
    logic signed [DW-1:0] r;
    r = x[DW-1:0];
    if (sat_en && (x[2*DW-1:DW-1] != '0) && (x[2*DW-1:DW-1] != '1))
      r = x[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return r;
  endfunction

  // One lane of the ALU; operands are widened so add/sub/mul never lose bits
  // before the truncate/saturate step.
  function automatic logic signed [DW-1:0] alu_lane(input logic [7:0] op,
                                                     input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] wa;
    logic signed [2*DW-1:0] wb;
    logic signed [2*DW-1:0] w;
    logic                   sat_en;
    wa     = a;
    wb     = b;
    w      = wa;
    sat_en = 1'b0;
    case (op)
      8'd1:    begin w = wa + wb; sat_en = SAT_EN; end
      8'd2:    begin w = wa - wb; sat_en = SAT_EN; end
      8'd3:    begin w = wa * wb; sat_en = SAT_EN; end
      8'd4:    w = (wa > wb) ? wa : wb;
      8'd5:    w = (wa < wb) ? wa : wb;
      8'd6:    w = wb;
      default: w = wa;
    endcase
    return sat_trunc(w, sat_en);
  endfunction

  logic [7:0]    fw_op_q [MAX_CHAINS];
  logic [AW-1:0] fw_rd_q [MAX_CHAINS];
  logic          fw_ce_q [MAX_CHAINS];
  logic [AW-1:0] fw_ca_q [MAX_CHAINS];
  logic [PW-1:0] cfg_ptr_q, cfg_ptr_d;
  logic          cfg_wr;
  logic [CW-1:0] cfg_chain;
  logic [1:0]    cfg_field;

  logic                 accept;
  logic [AW-1:0]        rd_addr;
  logic                 vld_p1_q;
  logic                 eof_p1_q;
  logic [CW-1:0]        chain_p1_q;
  logic [7:0]           op_p1_q;
  logic                 ce_p1_q;
  logic [AW-1:0]        ca_p1_q;
  logic [N-1:0][DW-1:0] a_p1_q;
  logic [N-1:0][DW-1:0] b_p1_q;

  logic [N-1:0][DW-1:0] vvrf_q [VVRF_SIZE];
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [N-1:0][DW-1:0] alu_d;

  assign cfg_wr    = (configId == 8'(PERSONAL_CONFIG_ID));
  assign cfg_field = cfg_ptr_q[1:0];
  assign cfg_chain = cfg_ptr_q[PW-1:2];
  assign cfg_ptr_d = cfg_ptr_q + PW'(1);
  assign accept    = valid_in & tracing;
  assign rd_addr   = fw_rd_q[chainId_in];
  assign wr_en     = vld_p1_q & ce_p1_q;
  assign wr_addr   = ca_p1_q;

  // Config bus: each byte lands in the field addressed by the running pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ptr_q <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw_op_q[c] <= '0;
        fw_rd_q[c] <= '0;
        fw_ce_q[c] <= 1'b0;
        fw_ca_q[c] <= '0;
      end
    end else if (cfg_wr) begin
      cfg_ptr_q <= cfg_ptr_d;
      case (cfg_field)
        2'd0:    fw_op_q[cfg_chain] <= configData;
        2'd1:    fw_rd_q[cfg_chain] <= configData[AW-1:0];
        2'd2:    fw_ce_q[cfg_chain] <= configData[0];
        default: fw_ca_q[cfg_chain] <= configData[AW-1:0];
      endcase
    end
  end

  // Stage 1 valid: only accepted vectors enter the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= accept;
  end

  // Stage 1 data: capture vector, tags, firmware snapshot and VVRF operand;
  // a write landing on the same edge and address is forwarded to the read
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1_q     <= vector_in;
      eof_p1_q   <= eof_in;
      chain_p1_q <= chainId_in;
      op_p1_q    <= fw_op_q[chainId_in];
      ce_p1_q    <= fw_ce_q[chainId_in];
      ca_p1_q    <= fw_ca_q[chainId_in];
      b_p1_q     <= (wr_en && (wr_addr == rd_addr)) ? alu_d : vvrf_q[rd_addr];
    end
  end

  // Lane-wise ALU feeding both the output register and the VVRF write port
  always_comb begin
    alu_d = '0;
    for (int l = 0; l < N; l++)
      alu_d[l] = alu_lane(op_p1_q, a_p1_q[l], b_p1_q[l]);
  end

  // Stage 2: register the result and its tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= '0;
      vector_out  <= '0;
    end else begin
      valid_out <= vld_p1_q;
      if (vld_p1_q) begin
        eof_out     <= eof_p1_q;
        chainId_out <= chain_p1_q;
        vector_out  <= alu_d;
      end
    end
  end

  // VVRF write-back of cached results; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) vvrf_q[wr_addr] <= alu_d;
  end

endmodule

// File: tb/tb_vv_alu_pipelined.sv
// Bench for vv_alu_pipelined: a wrapping and a saturating instance share all
// inputs and are compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_vv_alu_pipelined;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int MC = 4;
  localparam int CW = 2;
  localparam int VS = 8;
  localparam int ID = 5;
  localparam logic [7:0] IDLE_ID = 8'hFF;
  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tracing = 1'b0;
  logic          valid_in = 1'b0;
  logic          eof_in = 1'b0;
  logic [CW-1:0] chainId_in = '0;
  logic [7:0]    configId = IDLE_ID;
  logic [7:0]    configData = '0;
  vec_t          vector_in = '0;

  vec_t          vout_w, vout_s;
  logic [CW-1:0] cid_w, cid_s;
  logic          vld_w, vld_s, eof_w, eof_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vv_alu_pipelined #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(ID),
                     .VVRF_SIZE(VS), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
    .chainId_in(chainId_in), .configId(configId), .configData(configData),
    .vector_in(vector_in), .vector_out(vout_w), .chainId_out(cid_w),
    .valid_out(vld_w), .eof_out(eof_w));

  vv_alu_pipelined #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(ID),
                     .VVRF_SIZE(VS), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
    .chainId_in(chainId_in), .configId(configId), .configData(configData),
    .vector_in(vector_in), .vector_out(vout_s), .chainId_out(cid_s),
    .valid_out(vld_s), .eof_out(eof_s));

  // Reference model state: firmware, config pointer, VVRF per instance,
  // the vector in flight and the currently visible output.
  int m_op[MC], m_rd[MC], m_ce[MC], m_ca[MC];
  int m_k;
  int m_vvrf[2][VS][N];
  bit s1_v, s1_eof, s1_ce;
  int s1_chain, s1_ca;
  int s1_res[2][N];
  bit o_v, o_eof;
  int o_chain;
  int o_res[2][N];
  int p_op[MC], p_rd[MC], p_ce[MC], p_ca[MC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic int wrap_dw(input longint r);
    longint w;
    w = r & ((64'sd1 <<< DW) - 1);
    if (w >= (64'sd1 <<< (DW - 1))) w = w - (64'sd1 <<< DW);
    return int'(w);
  endfunction

  function automatic int ref_alu(input int op, input int a, input int b, input bit sat);
    longint r;
    longint hi;
    hi = (64'sd1 <<< (DW - 1)) - 1;
    case (op)
      1:       r = longint'(a) + b;
      2:       r = longint'(a) - b;
      3:       r = longint'(a) * b;
      4:       r = (a > b) ? a : b;
      5:       r = (a < b) ? a : b;
      6:       r = b;
      default: r = a;
    endcase
    if (sat && op >= 1 && op <= 3) begin
      if (r > hi) r = hi;
      else if (r < -hi - 1) r = -hi - 1;
    end
    return wrap_dw(r);
  endfunction

  function automatic vec_t splat(input int v);
    vec_t r;
    for (int l = 0; l < N; l++) r[l] = DW'(v);
    return r;
  endfunction

  function automatic vec_t pack_res(input int w);
    vec_t r;
    for (int l = 0; l < N; l++) r[l] = DW'(o_res[w][l]);
    return r;
  endfunction

  task automatic model_reset();
    s1_v = 1'b0; o_v = 1'b0; o_eof = 1'b0; o_chain = 0; m_k = 0;
    for (int i = 0; i < 2; i++)
      for (int l = 0; l < N; l++) o_res[i][l] = 0;
    for (int c = 0; c < MC; c++) begin
      m_op[c] = 0; m_rd[c] = 0; m_ce[c] = 0; m_ca[c] = 0;
    end
  endtask

  // One clock edge of the transaction model: retire the in-flight vector
  // (making its cached result visible to later reads), accept a new vector
  // using the firmware as it was before this edge, then apply a config byte.
  task automatic model_edge();
    int c, a;
    if (s1_v && s1_ce)
      for (int i = 0; i < 2; i++)
        for (int l = 0; l < N; l++) m_vvrf[i][s1_ca][l] = s1_res[i][l];
    o_v = s1_v;
    if (s1_v) begin
      o_res = s1_res; o_eof = s1_eof; o_chain = s1_chain;
    end
    if (valid_in && tracing) begin
      c = int'(chainId_in);
      for (int i = 0; i < 2; i++)
        for (int l = 0; l < N; l++) begin
          a = $signed(vector_in[l]);
          s1_res[i][l] = ref_alu(m_op[c], a, m_vvrf[i][m_rd[c]][l], (i == 1));
        end
      s1_v = 1'b1; s1_eof = eof_in; s1_chain = c; s1_ce = (m_ce[c] != 0); s1_ca = m_ca[c];
    end else begin
      s1_v = 1'b0;
    end
    if (configId == ID) begin
      c = m_k / 4;
      case (m_k % 4)
        0:       m_op[c] = int'(configData);
        1:       m_rd[c] = int'(configData) % VS;
        2:       m_ce[c] = int'(configData) & 1;
        default: m_ca[c] = int'(configData) % VS;
      endcase
      m_k = (m_k + 1) % (4 * MC);
    end
  endtask

  task automatic check_outputs();
    chk("valid_w", vld_w, o_v);
    chk("valid_s", vld_s, o_v);
    if (o_v) begin
      chk("vec_w", vout_w, pack_res(0));
      chk("vec_s", vout_s, pack_res(1));
      chk("chain_w", cid_w, o_chain);
      chk("chain_s", cid_s, o_chain);
      chk("eof_w", eof_w, o_eof);
      chk("eof_s", eof_s, o_eof);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; valid_in = 1'b0; configId = IDLE_ID;
    model_reset();
    #1;
    chk("rst_valid_w", vld_w, 0);
    chk("rst_valid_s", vld_s, 0);
    chk("rst_vec_w", vout_w, 0);
    chk("rst_vec_s", vout_s, 0);
    chk("rst_chain_w", cid_w, 0);
    chk("rst_eof_w", eof_w, 0);
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input int ch, input bit eof, input vec_t v);
    valid_in = 1'b1; chainId_in = CW'(ch); eof_in = eof; vector_in = v;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic clear_prog();
    for (int c = 0; c < MC; c++) begin
      p_op[c] = 0; p_rd[c] = 0; p_ce[c] = 0; p_ca[c] = 0;
    end
  endtask

  // Writes the whole table so the byte pointer ends where it started
  task automatic program_fw();
    valid_in = 1'b0;
    for (int k = 0; k < 4 * MC; k++) begin
      configId = 8'(ID);
      case (k % 4)
        0:       configData = 8'(p_op[k / 4]);
        1:       configData = 8'(p_rd[k / 4]);
        2:       configData = 8'(p_ce[k / 4]);
        default: configData = 8'(p_ca[k / 4]);
      endcase
      tick();
    end
    configId = IDLE_ID;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    do_reset(2);
    tracing = 1'b1;

    // Pass-through after reset
    for (int l = 0; l < N; l++) v[l] = DW'(l + 1);
    send(0, 1'b1, v);
    idle();
    chk("pass_valid", vld_w, 1);
    chk("pass_vec", vout_w, v);
    chk("pass_chain", cid_w, 0);

    // Load every VVRF entry with a known value
    for (int a = 0; a < VS; a++) begin
      clear_prog(); p_ce[0] = 1; p_ca[0] = a;
      program_fw();
      send(0, 1'b0, splat(3 * a + 1));
    end
    idle();

    // Cache then read back
    clear_prog(); p_ce[1] = 1; p_ca[1] = 3; p_op[2] = 1; p_rd[2] = 3;
    program_fw();
    send(1, 1'b0, splat(5));
    idle();
    send(2, 1'b0, splat(2));
    idle();
    chk("cache_add", vout_w, splat(7));

    // Back-to-back write then read of the same entry
    send(1, 1'b0, splat(9));
    send(2, 1'b1, splat(1));
    idle();
    chk("fwd_add", vout_w, splat(10));

    // Saturation versus wrap-around
    clear_prog(); p_ce[0] = 1; p_ca[0] = 3; p_ce[1] = 1; p_ca[1] = 4;
    program_fw();
    send(0, 1'b0, splat(100));
    send(1, 1'b0, splat(16));
    idle();
    clear_prog();
    p_op[0] = 1; p_rd[0] = 3; p_op[1] = 2; p_rd[1] = 3; p_op[2] = 3; p_rd[2] = 4;
    program_fw();
    send(0, 1'b0, splat(100));
    idle();
    chk("sat_add_s", vout_s, splat(127));
    chk("wrap_add_w", vout_w, splat(-56));
    send(1, 1'b0, splat(-100));
    idle();
    chk("sat_sub_s", vout_s, splat(-128));
    chk("wrap_sub_w", vout_w, splat(56));
    send(2, 1'b0, splat(16));
    idle();
    chk("sat_mul_s", vout_s, splat(127));
    chk("wrap_mul_w", vout_w, splat(0));

    // Min/max, op 6 and an out-of-range op
    clear_prog(); p_ce[0] = 1; p_ca[0] = 2;
    program_fw();
    send(0, 1'b0, splat(2));
    idle();
    clear_prog();
    p_op[0] = 4; p_op[1] = 5; p_op[2] = 6; p_op[3] = 200;
    for (int c = 0; c < MC; c++) p_rd[c] = 2;
    program_fw();
    send(0, 1'b0, splat(-3));
    send(1, 1'b0, splat(-3));
    chk("max_w", vout_w, splat(2));
    send(2, 1'b0, splat(-3));
    chk("min_w", vout_w, splat(-3));
    chk("min_s", vout_s, splat(-3));
    send(3, 1'b0, splat(-3));
    chk("opb_w", vout_w, splat(2));
    idle();
    chk("op200_w", vout_w, splat(-3));

    // Tracing dropped while a vector is in flight
    clear_prog();
    program_fw();
    send(0, 1'b1, splat(33));
    valid_in = 1'b1; tracing = 1'b0; vector_in = splat(44);
    tick();
    chk("trace_inflight_vld", vld_w, 1);
    chk("trace_inflight_vec", vout_w, splat(33));
    tick();
    chk("trace_drop_vld", vld_w, 0);
    valid_in = 1'b0; tracing = 1'b1;

    // Reset with a caching vector in stage 1
    clear_prog(); p_ce[1] = 1; p_ca[1] = 5; p_op[2] = 6; p_rd[2] = 5;
    program_fw();
    send(1, 1'b0, splat(77));
    do_reset(2);
    send(2, 1'b0, splat(11));
    idle();
    chk("rst_fw_pass", vout_w, splat(11));
    clear_prog(); p_op[2] = 6; p_rd[2] = 5;
    program_fw();
    send(2, 1'b0, splat(0));
    idle();
    chk("rst_no_cache", vout_w, splat(16));

    // Randomised traffic with interleaved config writes and one reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      valid_in   = ($urandom_range(0, 3) != 0);
      tracing    = ($urandom_range(0, 7) != 0);
      eof_in     = 1'($urandom);
      chainId_in = CW'($urandom);
      for (int l = 0; l < N; l++) vector_in[l] = DW'($urandom);
      configId   = ($urandom_range(0, 3) == 0) ? 8'(ID) : 8'($urandom_range(0, 4));
      configData = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      tick();
    end
    valid_in = 1'b0;
    configId = IDLE_ID;
    tracing  = 1'b1;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
